// File: rtl/flag_pkg.sv
// Shared constants and types for the status-flag unit: operation codes,
// operand-size codes, flag bit positions and the packed flag-word helper.
package flag_pkg;

  // Flag operation codes carried on iFSel.
  localparam logic [4:0] FS_ADD   = 5'd0;
  localparam logic [4:0] FS_OR    = 5'd1;
  localparam logic [4:0] FS_ADC   = 5'd2;
  localparam logic [4:0] FS_SBB   = 5'd3;
  localparam logic [4:0] FS_AND   = 5'd4;
  localparam logic [4:0] FS_SUB   = 5'd5;
  localparam logic [4:0] FS_XOR   = 5'd6;
  localparam logic [4:0] FS_CMP   = 5'd7;
  localparam logic [4:0] FS_INC   = 5'd8;
  localparam logic [4:0] FS_DEC   = 5'd9;
  localparam logic [4:0] FS_NOT   = 5'd10;
  localparam logic [4:0] FS_NEG   = 5'd11;
  localparam logic [4:0] FS_TEST  = 5'd12;
  localparam logic [4:0] FS_MUL   = 5'd18;
  localparam logic [4:0] FS_ADJ   = 5'd20;
  localparam logic [4:0] FS_SHF   = 5'd21;
  localparam logic [4:0] FS_CMC   = 5'd22;
  localparam logic [4:0] FS_CLC   = 5'd23;
  localparam logic [4:0] FS_CLI   = 5'd24;
  localparam logic [4:0] FS_CLD   = 5'd25;
  localparam logic [4:0] FS_STC   = 5'd26;
  localparam logic [4:0] FS_STI   = 5'd27;
  localparam logic [4:0] FS_STD   = 5'd28;
  localparam logic [4:0] FS_LDLO  = 5'd29;
  localparam logic [4:0] FS_LDALL = 5'd30;

  // Operand size codes carried on iSize.
  localparam logic [1:0] SZ_BYTE  = 2'd0;
  localparam logic [1:0] SZ_WORD  = 2'd1;
  localparam logic [1:0] SZ_DWORD = 2'd2;
  localparam logic [1:0] SZ_RSVD  = 2'd3;

  // Bit positions inside the packed flag word.
  localparam int unsigned FB_CF = 0;
  localparam int unsigned FB_PF = 2;
  localparam int unsigned FB_AF = 4;
  localparam int unsigned FB_ZF = 6;
  localparam int unsigned FB_SF = 7;
  localparam int unsigned FB_TF = 8;
  localparam int unsigned FB_IF = 9;
  localparam int unsigned FB_DF = 10;
  localparam int unsigned FB_OF = 11;

  // Packed word with every writable flag clear; fixed bits 15:12 and 1 read as 1.
  localparam logic [15:0] FLAGS_RST = 16'hF002;

  typedef struct packed {
    logic of_f;
    logic df_f;
    logic if_f;
    logic tf_f;
    logic sf_f;
    logic zf_f;
    logic af_f;
    logic pf_f;
    logic cf_f;
  } flags_t;

  function automatic logic [15:0] pack_flags(input flags_t f);
    logic [15:0] w;
    w        = FLAGS_RST;
    w[FB_CF] = f.cf_f;
    w[FB_PF] = f.pf_f;
    w[FB_AF] = f.af_f;
    w[FB_ZF] = f.zf_f;
    w[FB_SF] = f.sf_f;
    w[FB_TF] = f.tf_f;
    w[FB_IF] = f.if_f;
    w[FB_DF] = f.df_f;
    w[FB_OF] = f.of_f;
    return w;
  endfunction

endpackage

// File: rtl/flag_unit_stk_stack.sv
// Register-array LIFO holding saved flag sets for interrupt entry/return.
// Reports which request was accepted so the flag logic can act on it.
module flag_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 3,
  parameter int unsigned WIDTH = 9
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iPush,
  input  logic             iPop,
  input  logic [WIDTH-1:0] iData,
  output logic [WIDTH-1:0] oTop,
  output logic             oPushOk,
  output logic             oPopOk,
  output logic [CNT_W-1:0] oCnt,
  output logic             oErr
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;

  logic          w_full;
  logic          w_empty;
  logic          w_err;
  logic [AW-1:0] w_wr_idx;
  logic [AW-1:0] w_rd_idx;

  assign w_full   = (r_cnt == CNT_W'(DEPTH));
  assign w_empty  = (r_cnt == '0);
  assign oPushOk  = iPush & ~iPop & ~w_full;
  assign oPopOk   = iPop & ~iPush & ~w_empty;
  // Simultaneous push+pop is treated as a collision and both are dropped.
  assign w_err    = (iPush & iPop) | (iPush & w_full) | (iPop & w_empty);
  assign w_wr_idx = AW'(r_cnt);
  assign w_rd_idx = AW'(r_cnt - CNT_W'(1));
  assign oTop     = r_mem[w_rd_idx];
  assign oCnt     = r_cnt;
  assign oErr     = r_err;

  // Storage array; contents after reset are don't-care, so no reset here.
  always_ff @(posedge iClk) begin
    if (oPushOk) begin
      r_mem[w_wr_idx] <= iData;
    end
  end

  // Occupancy counter and one-cycle error pulse.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_err <= w_err;
      if (oPushOk) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (oPopOk) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/flag_unit_stk.sv
// Execute-stage status-flag unit: computes OF/DF/IF/TF/SF/ZF/AF/PF/CF for
// 8/16/32-bit operations, saves/restores flags on a hardware stack and
// raises single-step trap requests with a one-instruction shadow.
module flag_unit_stk
  import flag_pkg::*;
#(
  parameter int unsigned DW        = 16,
  parameter int unsigned STK_DEPTH = 4,
  parameter int unsigned CNT_W     = 3
) (
  input  logic             iClk,
  input  logic             iRstN,
  input  logic             iValid,
  input  logic [4:0]       iFSel,
  input  logic [1:0]       iSize,
  input  logic [DW:0]      iRes,
  input  logic [DW-1:0]    iOpA,
  input  logic [DW-1:0]    iOpB,
  input  logic [DW-1:0]    iAux,
  input  logic             iShfCF,
  input  logic             iShfOF,
  input  logic             iMulF,
  input  logic             iAdjCF,
  input  logic             iAdjAF,
  input  logic             iPush,
  input  logic             iPop,
  input  logic             iInsnEnd,
  output logic [15:0]      oFlags,
  output logic [CNT_W-1:0] oStkCnt,
  output logic             oStkErr,
  output logic             oTrapReq
);

  flags_t r_flags;
  logic   r_shadow;
  logic   r_trap;

  // Operands padded to the widest size so every size uses the same indices.
  logic [32:0] w_res;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic [31:0] w_aux;
  logic        w_unused;

  logic   w_size_ok;
  logic   w_cy;
  logic   w_r_msb;
  logic   w_a_msb;
  logic   w_b_msb;
  logic   w_r_zero;
  logic   w_r_min;
  logic   w_x_msb;
  logic   w_x_zero;
  logic   w_res_par;
  logic   w_aux_par;
  logic   w_of_add;
  logic   w_of_sub;
  logic   w_af_ab;
  flags_t w_upd;
  flags_t w_flags_d;
  flags_t w_stk_top;
  logic   w_push_ok;
  logic   w_pop_ok;
  logic   w_shadow_d;
  logic   w_trap_d;

  assign w_res    = 33'(iRes);
  assign w_a      = 32'(iOpA);
  assign w_b      = 32'(iOpB);
  assign w_aux    = 32'(iAux);
  assign w_unused = ^{w_a, w_b};

  assign w_res_par = ~^w_res[7:0];
  assign w_aux_par = ~^w_aux[7:0];
  assign w_of_add  = (~w_a_msb & ~w_b_msb & w_r_msb) | (w_a_msb & w_b_msb & ~w_r_msb);
  assign w_of_sub  = (~w_a_msb & w_b_msb & w_r_msb) | (w_a_msb & ~w_b_msb & ~w_r_msb);
  assign w_af_ab   = w_res[4] ^ w_a[4] ^ w_b[4];

  // Select sign/carry/zero taps for the operand size; dword needs DW=32.
  always_comb begin
    w_size_ok = 1'b1;
    w_cy      = 1'b0;
    w_r_msb   = 1'b0;
    w_a_msb   = 1'b0;
    w_b_msb   = 1'b0;
    w_r_zero  = 1'b0;
    w_r_min   = 1'b0;
    w_x_msb   = 1'b0;
    w_x_zero  = 1'b0;
    case (iSize)
      SZ_BYTE: begin
        w_cy     = w_res[8];
        w_r_msb  = w_res[7];
        w_a_msb  = w_a[7];
        w_b_msb  = w_b[7];
        w_r_zero = (w_res[7:0] == '0);
        w_r_min  = (w_res[7:0] == 8'h80);
        w_x_msb  = w_aux[7];
        w_x_zero = (w_aux[7:0] == '0);
      end
      SZ_WORD: begin
        w_cy     = w_res[16];
        w_r_msb  = w_res[15];
        w_a_msb  = w_a[15];
        w_b_msb  = w_b[15];
        w_r_zero = (w_res[15:0] == '0);
        w_r_min  = (w_res[15:0] == 16'h8000);
        w_x_msb  = w_aux[15];
        w_x_zero = (w_aux[15:0] == '0);
      end
      SZ_DWORD: begin
        w_size_ok = (DW == 32);
        w_cy      = w_res[32];
        w_r_msb   = w_res[31];
        w_a_msb   = w_a[31];
        w_b_msb   = w_b[31];
        w_r_zero  = (w_res[31:0] == '0);
        w_r_min   = (w_res[31:0] == 32'h8000_0000);
        w_x_msb   = w_aux[31];
        w_x_zero  = (w_aux[31:0] == '0);
      end
      default: w_size_ok = 1'b0;
    endcase
  end

  // Flag update requested by iFSel, before stack overrides.
  always_comb begin
    w_upd = r_flags;
    if (iValid && w_size_ok) begin
      case (iFSel)
        FS_ADD, FS_ADC: begin
          w_upd.cf_f = w_cy;
          w_upd.of_f = w_of_add;
          w_upd.af_f = w_af_ab;
          w_upd.sf_f = w_r_msb;
          w_upd.zf_f = w_r_zero;
          w_upd.pf_f = w_res_par;
        end
        FS_SBB, FS_SUB, FS_CMP: begin
          w_upd.cf_f = w_cy;
          w_upd.of_f = w_of_sub;
          w_upd.af_f = w_af_ab;
          w_upd.sf_f = w_r_msb;
          w_upd.zf_f = w_r_zero;
          w_upd.pf_f = w_res_par;
        end
        FS_NEG: begin
          w_upd.cf_f = w_cy;
          w_upd.of_f = w_r_min;
          w_upd.af_f = w_res[4] ^ w_a[4];
          w_upd.sf_f = w_r_msb;
          w_upd.zf_f = w_r_zero;
          w_upd.pf_f = w_res_par;
        end
        FS_OR, FS_AND, FS_XOR, FS_TEST: begin
          w_upd.cf_f = 1'b0;
          w_upd.of_f = 1'b0;
          w_upd.sf_f = w_r_msb;
          w_upd.zf_f = w_r_zero;
          w_upd.pf_f = w_res_par;
        end
        FS_INC, FS_DEC: begin
          // Implicit second operand is 1, so only a[4] feeds the half-carry.
          w_upd.of_f = (iFSel == FS_INC) ? (~w_a_msb & w_r_msb) : (w_a_msb & ~w_r_msb);
          w_upd.af_f = w_res[4] ^ w_a[4];
          w_upd.sf_f = w_r_msb;
          w_upd.zf_f = w_r_zero;
          w_upd.pf_f = w_res_par;
        end
        FS_MUL: begin
          w_upd.cf_f = iMulF;
          w_upd.of_f = iMulF;
          w_upd.sf_f = w_x_msb;
          w_upd.zf_f = w_x_zero;
          w_upd.pf_f = w_aux_par;
        end
        FS_ADJ: begin
          w_upd.cf_f = iAdjCF;
          w_upd.af_f = iAdjAF;
          w_upd.sf_f = w_aux[7];
          w_upd.zf_f = (w_aux[7:0] == '0);
          w_upd.pf_f = w_aux_par;
        end
        FS_SHF: begin
          w_upd.cf_f = iShfCF;
          w_upd.of_f = iShfOF;
          w_upd.sf_f = w_x_msb;
          w_upd.zf_f = w_x_zero;
          w_upd.pf_f = w_aux_par;
        end
        FS_CMC: w_upd.cf_f = ~r_flags.cf_f;
        FS_CLC: w_upd.cf_f = 1'b0;
        FS_CLI: w_upd.if_f = 1'b0;
        FS_CLD: w_upd.df_f = 1'b0;
        FS_STC: w_upd.cf_f = 1'b1;
        FS_STI: w_upd.if_f = 1'b1;
        FS_STD: w_upd.df_f = 1'b1;
        FS_LDLO, FS_LDALL: begin
          w_upd.sf_f = w_res[7];
          w_upd.zf_f = w_res[6];
          w_upd.af_f = w_res[4];
          w_upd.pf_f = w_res[2];
          w_upd.cf_f = w_res[0];
          if (iFSel == FS_LDALL) begin
            w_upd.of_f = w_res[11];
            w_upd.df_f = w_res[10];
            w_upd.if_f = w_res[9];
            w_upd.tf_f = w_res[8];
          end
        end
        default: ;
      endcase
    end
  end

  // Stack overrides: pop restores everything, push masks IF/TF only.
  always_comb begin
    w_flags_d = w_upd;
    if (w_pop_ok) begin
      w_flags_d = w_stk_top;
    end else if (w_push_ok) begin
      w_flags_d.if_f = 1'b0;
      w_flags_d.tf_f = 1'b0;
    end
  end

  // Single-step: a fresh TF arms the shadow so the instruction that set it
  // retires without trapping; an interrupt push at retire swallows the trap.
  always_comb begin
    w_shadow_d = r_shadow;
    if (iInsnEnd) begin
      w_shadow_d = 1'b0;
    end
    if (!r_flags.tf_f && w_flags_d.tf_f) begin
      w_shadow_d = 1'b1;
    end
    w_trap_d = iInsnEnd & r_flags.tf_f & ~r_shadow & ~w_push_ok;
  end

  // Flag, shadow and trap registers.
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      r_flags  <= '0;
      r_shadow <= 1'b0;
      r_trap   <= 1'b0;
    end else begin
      r_flags  <= w_flags_d;
      r_shadow <= w_shadow_d;
      r_trap   <= w_trap_d;
    end
  end

  flag_stack #(
    .DEPTH (STK_DEPTH),
    .CNT_W (CNT_W),
    .WIDTH ($bits(flags_t))
  ) u_stack (
    .iClk    (iClk),
    .iRstN   (iRstN),
    .iPush   (iPush),
    .iPop    (iPop),
    .iData   (r_flags),
    .oTop    (w_stk_top),
    .oPushOk (w_push_ok),
    .oPopOk  (w_pop_ok),
    .oCnt    (oStkCnt),
    .oErr    (oStkErr)
  );

  assign oFlags   = pack_flags(r_flags);
  assign oTrapReq = r_trap;

endmodule

// File: tb/tb_flag_unit_stk.sv
// Scoreboard bench for flag_unit_stk (DW=32, 4-entry stack): each cycle's
// expected outputs are queued as stimulus is driven and compared after the edge.
module tb_flag_unit_stk;

  localparam int unsigned DW        = 32;
  localparam int unsigned STK_DEPTH = 4;
  localparam int unsigned CNT_W     = 3;

  localparam logic [4:0] OP_ADD = 5'd0, OP_AND = 5'd4, OP_SUB = 5'd5, OP_NEG = 5'd11;
  localparam logic [4:0] OP_CLC = 5'd23, OP_STC = 5'd26, OP_STI = 5'd27, OP_LDALL = 5'd30;

  logic             iClk;
  logic             iRstN;
  logic             iValid;
  logic [4:0]       iFSel;
  logic [1:0]       iSize;
  logic [DW:0]      iRes;
  logic [DW-1:0]    iOpA;
  logic [DW-1:0]    iOpB;
  logic [DW-1:0]    iAux;
  logic             iShfCF;
  logic             iShfOF;
  logic             iMulF;
  logic             iAdjCF;
  logic             iAdjAF;
  logic             iPush;
  logic             iPop;
  logic             iInsnEnd;
  logic [15:0]      oFlags;
  logic [CNT_W-1:0] oStkCnt;
  logic             oStkErr;
  logic             oTrapReq;

  flag_unit_stk #(
    .DW        (DW),
    .STK_DEPTH (STK_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .iClk     (iClk),
    .iRstN    (iRstN),
    .iValid   (iValid),
    .iFSel    (iFSel),
    .iSize    (iSize),
    .iRes     (iRes),
    .iOpA     (iOpA),
    .iOpB     (iOpB),
    .iAux     (iAux),
    .iShfCF   (iShfCF),
    .iShfOF   (iShfOF),
    .iMulF    (iMulF),
    .iAdjCF   (iAdjCF),
    .iAdjAF   (iAdjAF),
    .iPush    (iPush),
    .iPop     (iPop),
    .iInsnEnd (iInsnEnd),
    .oFlags   (oFlags),
    .oStkCnt  (oStkCnt),
    .oStkErr  (oStkErr),
    .oTrapReq (oTrapReq)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    string            tag;
    logic [15:0]      flags;
    logic [15:0]      mask;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             trap;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [15:0] f, input logic [15:0] m,
                            input int c, input bit e, input bit t);
    exp_t x;
    x.tag   = tag;
    x.flags = f;
    x.mask  = m;
    x.cnt   = CNT_W'(c);
    x.err   = e;
    x.trap  = t;
    sb_q.push_back(x);
  endtask

  task automatic compare_out();
    exp_t x;
    if (sb_q.size() == 0) begin
      check_eq("sb_underflow", 32'(sb_q.size()), 32'd1);
      return;
    end
    x = sb_q.pop_front();
    check_eq({x.tag, ".flags"}, 32'(oFlags & x.mask), 32'(x.flags & x.mask));
    check_eq({x.tag, ".cnt"}, 32'(oStkCnt), 32'(x.cnt));
    check_eq({x.tag, ".err"}, 32'(oStkErr), 32'(x.err));
    check_eq({x.tag, ".trap"}, 32'(oTrapReq), 32'(x.trap));
  endtask

  task automatic idle();
    iValid   = 1'b0;
    iFSel    = '0;
    iSize    = '0;
    iRes     = '0;
    iOpA     = '0;
    iOpB     = '0;
    iAux     = '0;
    iShfCF   = 1'b0;
    iShfOF   = 1'b0;
    iMulF    = 1'b0;
    iAdjCF   = 1'b0;
    iAdjAF   = 1'b0;
    iPush    = 1'b0;
    iPop     = 1'b0;
    iInsnEnd = 1'b0;
  endtask

  task automatic alu(input logic [4:0] fsel, input logic [1:0] sz, input logic [DW:0] res,
                     input logic [DW-1:0] a, input logic [DW-1:0] b);
    iValid = 1'b1;
    iFSel  = fsel;
    iSize  = sz;
    iRes   = res;
    iOpA   = a;
    iOpB   = b;
  endtask

  // Queue the expectation, clock once, compare just after the edge, go idle.
  task automatic cycle(input string tag, input logic [15:0] f, input logic [15:0] m,
                       input int c, input bit e, input bit t);
    expect_out(tag, f, m, c, e, t);
    @(posedge iClk);
    #1;
    compare_out();
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    idle();
    iRstN = 1'b0;
    #12;
    expect_out("reset", 16'hF002, 16'hFFFF, 0, 1'b0, 1'b0);
    compare_out();
    @(negedge iClk);
    iRstN = 1'b1;

    alu(OP_ADD, 2'd0, 33'h0_0000_0080, 32'h7F, 32'h01);
    cycle("add8", 16'hF892, 16'hFFFF, 0, 1'b0, 1'b0);

    alu(OP_AND, 2'd0, 33'h0, 32'h0F, 32'hF0);
    cycle("and8_zero", 16'hF056, 16'hFFFF, 0, 1'b0, 1'b0);

    alu(OP_SUB, 2'd2, 33'h1_FFFF_FFFF, 32'h0, 32'h1);
    cycle("sub32", 16'hF097, 16'hFFFF, 0, 1'b0, 1'b0);

    alu(OP_SUB, 2'd3, 33'h0_0000_0000, 32'h5, 32'h5);
    cycle("size_rsvd", 16'hF097, 16'hFFFF, 0, 1'b0, 1'b0);

    alu(OP_ADD, 2'd1, 33'h0_0000_8000, 32'h7FFF, 32'h0001);
    cycle("add16", 16'hF896, 16'hFFFF, 0, 1'b0, 1'b0);

    alu(OP_CLC, 2'd0, '0, '0, '0);
    cycle("clc", 16'hF896, 16'hFFFF, 0, 1'b0, 1'b0);

    alu(OP_STI, 2'd0, '0, '0, '0);
    cycle("sti", 16'hFA96, 16'hFFFF, 0, 1'b0, 1'b0);

    alu(OP_STC, 2'd0, '0, '0, '0);
    iPush = 1'b1;
    cycle("push_stc", 16'hF897, 16'hFFFF, 1, 1'b0, 1'b0);

    iPop = 1'b1;
    cycle("pop_restore", 16'hFA96, 16'hFFFF, 0, 1'b0, 1'b0);

    for (int i = 0; i <= int'(STK_DEPTH); i++) begin
      iPush = 1'b1;
      cycle($sformatf("push%0d", i), 16'hF896, 16'hFFFF,
            (i < int'(STK_DEPTH)) ? i + 1 : int'(STK_DEPTH), i == int'(STK_DEPTH), 1'b0);
    end
    cycle("after_ovf", 16'hF896, 16'hFFFF, STK_DEPTH, 1'b0, 1'b0);

    for (int i = 0; i < int'(STK_DEPTH); i++) begin
      iPop = 1'b1;
      cycle($sformatf("pop%0d", i), (i == int'(STK_DEPTH) - 1) ? 16'hFA96 : 16'hF896,
            16'hFFFF, int'(STK_DEPTH) - 1 - i, 1'b0, 1'b0);
    end
    iPop = 1'b1;
    cycle("pop_empty", 16'hFA96, 16'hFFFF, 0, 1'b1, 1'b0);

    alu(OP_LDALL, 2'd0, 33'h0_0000_0100, '0, '0);
    cycle("ld_tf", 16'hF102, 16'hFFFF, 0, 1'b0, 1'b0);
    iInsnEnd = 1'b1;
    cycle("shadow_end", 16'hF102, 16'hFFFF, 0, 1'b0, 1'b0);
    cycle("shadow_idle", 16'hF102, 16'hFFFF, 0, 1'b0, 1'b0);
    iInsnEnd = 1'b1;
    cycle("trap_end", 16'hF102, 16'hFFFF, 0, 1'b0, 1'b1);
    cycle("trap_drop", 16'hF102, 16'hFFFF, 0, 1'b0, 1'b0);

    alu(OP_NEG, 2'd0, 33'h0_0000_0080, 32'h80, '0);
    iPush = 1'b1;
    iPop  = 1'b1;
    cycle("collide_neg", 16'hF982, 16'hFFEE, 0, 1'b1, 1'b0);
    cycle("collide_idle", 16'hF982, 16'hFFEE, 0, 1'b0, 1'b0);

    iPush = 1'b1;
    cycle("push_clr_tf", 16'hF882, 16'hFFEE, 1, 1'b0, 1'b0);

    #2;
    iRstN = 1'b0;
    #1;
    expect_out("async_rst", 16'hF002, 16'hFFFF, 0, 1'b0, 1'b0);
    compare_out();
    @(negedge iClk);
    iRstN = 1'b1;
    cycle("post_rst", 16'hF002, 16'hFFFF, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
